morse_encoder: RTL and testbench

//  Converts one character code at a time into an on/off Morse keying signal for an LED or buzzer.

---
 rtl/morse_encoder.sv | 182 ++++++++++++++++++
 tb/tb_morse_encoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// Morse keying encoder: one character code in, timed dots/dashes out.
// Symbol timing is derived from UNIT_CYCLES clock cycles per Morse unit.
module morse_encoder #(
  parameter int UNIT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  output logic       morse_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(7 * UNIT_CYCLES);

  localparam logic [CW-1:0] T1 = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] T3 = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] T7 = CW'(7 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SYM_GAP,
    CHAR_GAP,
    WORD_GAP,
    FINISH
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [4:0]    pat, pat_d;
  logic          err_d;
  logic          accept;
  logic [7:0]    rom_q;
  logic [2:0]    sel;
  logic          dash;
  logic [CW-1:0] mark_last;

  // {len, pat}: pat is right-aligned, MSB sent first, 1 = dash
  function automatic logic [7:0] rom(input logic [5:0] c);
    logic [7:0] r;
    r = 8'h00;
    case (c)
      6'd0:  r = {3'd2, 5'b00001};
      6'd1:  r = {3'd4, 5'b01000};
      6'd2:  r = {3'd4, 5'b01010};
      6'd3:  r = {3'd3, 5'b00100};
      6'd4:  r = {3'd1, 5'b00000};
      6'd5:  r = {3'd4, 5'b00010};
      6'd6:  r = {3'd3, 5'b00110};
      6'd7:  r = {3'd4, 5'b00000};
      6'd8:  r = {3'd2, 5'b00000};
      6'd9:  r = {3'd4, 5'b00111};
      6'd10: r = {3'd3, 5'b00101};
      6'd11: r = {3'd4, 5'b00100};
      6'd12: r = {3'd2, 5'b00011};
      6'd13: r = {3'd2, 5'b00010};
      6'd14: r = {3'd3, 5'b00111};
      6'd15: r = {3'd4, 5'b00110};
      6'd16: r = {3'd4, 5'b01101};
      6'd17: r = {3'd3, 5'b00010};
      6'd18: r = {3'd3, 5'b00000};
      6'd19: r = {3'd1, 5'b00001};
      6'd20: r = {3'd3, 5'b00001};
      6'd21: r = {3'd4, 5'b00001};
      6'd22: r = {3'd3, 5'b00011};
      6'd23: r = {3'd4, 5'b01001};
      6'd24: r = {3'd4, 5'b01011};
      6'd25: r = {3'd4, 5'b01100};
      6'd26: r = {3'd5, 5'b11111};
      6'd27: r = {3'd5, 5'b01111};
      6'd28: r = {3'd5, 5'b00111};
      6'd29: r = {3'd5, 5'b00011};
      6'd30: r = {3'd5, 5'b00001};
      6'd31: r = {3'd5, 5'b00000};
      6'd32: r = {3'd5, 5'b10000};
      6'd33: r = {3'd5, 5'b11000};
      6'd34: r = {3'd5, 5'b11100};
      6'd35: r = {3'd5, 5'b11110};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign rom_q      = rom(char_code);
  assign char_ready = (state == IDLE) & en;
  assign accept     = char_valid & char_ready;
  assign busy       = (state != IDLE);

  assign sel       = idx - 3'd1;
  assign dash      = pat[sel];
  assign mark_last = dash ? T3 : T1;

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    idx_d   = idx;
    pat_d   = pat;
    err_d   = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_d = '0;
          if (accept) begin
            if (char_code < 6'd36) begin
              state_d = MARK;
              idx_d   = rom_q[7:5];
              pat_d   = rom_q[4:0];
            end else if (char_code == 6'd36) begin
              state_d = WORD_GAP;
            end else begin
              state_d = FINISH;
              err_d   = 1'b1;
            end
          end
        end
        MARK: begin
          if (cnt == mark_last) begin
            cnt_d   = '0;
            idx_d   = idx - 3'd1;
            state_d = (idx == 3'd1) ? CHAR_GAP : SYM_GAP;
          end
        end
        SYM_GAP: begin
          if (cnt == T1) begin
            cnt_d   = '0;
            state_d = MARK;
          end
        end
        CHAR_GAP: begin
          if (cnt == T3) begin
            cnt_d   = '0;
            state_d = FINISH;
          end
        end
        WORD_GAP: begin
          if (cnt == T7) begin
            cnt_d   = '0;
            state_d = FINISH;
          end
        end
        FINISH: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      pat       <= '0;
      morse_out <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      pat       <= pat_d;
      morse_out <= (state_d == MARK);
      done      <= (state_d == FINISH);
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: directed scenarios plus random characters
// checked against a dot/dash string model.
module tb_morse_encoder;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       char_valid = 1'b0;
  logic [5:0] char_code = 6'd0;
  logic       char_ready;
  logic       morse_out;
  logic       busy;
  logic       done;
  logic       err;

  int passes = 0;
  int checks = 0;

  bit exp_q[$];
  bit exp_err;

  string mtab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
    "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
    "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
    "-.--", "--..", "-----", ".----", "..---", "...--",
    "....-", ".....", "-....", "--...", "---..", "----."
  };

  morse_encoder #(.UNIT_CYCLES(U)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .char_valid(char_valid),
    .char_code(char_code),
    .char_ready(char_ready),
    .morse_out(morse_out),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc,
                       input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cyc=%0d obs=%b exp=%b", tag, cyc, obs, exp);
  endtask

  // Expected keying waveform from cycle 1 up to the cycle before done
  task automatic build(input int code);
    string s;
    int n;
    exp_q.delete();
    exp_err = 1'b0;
    if (code < 36) begin
      s = mtab[code];
      for (int i = 0; i < s.len(); i++) begin
        n = (s[i] == 8'h2D) ? 3 * U : U;
        repeat (n) exp_q.push_back(1'b1);
        n = (i == s.len() - 1) ? 3 * U : U;
        repeat (n) exp_q.push_back(1'b0);
      end
    end else if (code == 36) begin
      repeat (7 * U) exp_q.push_back(1'b0);
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic wait_ready(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (char_ready === 1'b1) got = 1'b1;
    end
    check("ready_wait", 0, got, 1'b1);
  endtask

  task automatic accept(input int code);
    char_valid = 1'b1;
    char_code  = code[5:0];
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_code  = 6'($urandom);
  endtask

  task automatic run_char(input int code, input bit noise);
    int L;
    bit got;
    build(code);
    L = exp_q.size();
    wait_ready(got);
    if (got) begin
      accept(code);
      for (int k = 1; k <= L + 2; k++) begin
        @(negedge clk);
        if (k <= L) begin
          check("morse", k, morse_out, exp_q[k-1]);
          check("done_body", k, done, 1'b0);
          check("err_body", k, err, 1'b0);
          check("busy_body", k, busy, 1'b1);
          check("ready_body", k, char_ready, 1'b0);
        end else if (k == L + 1) begin
          check("done_pulse", k, done, 1'b1);
          check("err_pulse", k, err, exp_err);
          check("morse_fin", k, morse_out, 1'b0);
          check("busy_fin", k, busy, 1'b1);
        end else begin
          check("ready_after", k, char_ready, 1'b1);
          check("busy_after", k, busy, 1'b0);
          check("done_after", k, done, 1'b0);
          check("err_after", k, err, 1'b0);
        end
        if (noise && k < L) begin
          char_valid = 1'($urandom);
          char_code  = 6'($urandom);
        end else begin
          char_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    bit got;
    int code;

    #2;
    check("rst_ready", 0, char_ready, 1'b1);
    check("rst_morse", 0, morse_out, 1'b0);
    check("rst_busy", 0, busy, 1'b0);
    check("rst_done", 0, done, 1'b0);
    check("rst_err", 0, err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_char(4, 1'b0);
    run_char(0, 1'b0);
    run_char(26, 1'b1);
    run_char(36, 1'b0);
    run_char(45, 1'b0);

    // 'T' aborted by en falling
    wait_ready(got);
    if (got) begin
      accept(19);
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        check("abort_mark", k, morse_out, 1'b1);
      end
      en = 1'b0;
      for (int k = 7; k <= 20; k++) begin
        @(negedge clk);
        check("abort_morse", k, morse_out, 1'b0);
        check("abort_done", k, done, 1'b0);
        check("abort_busy", k, busy, 1'b0);
        check("abort_ready", k, char_ready, 1'b0);
      end
      en = 1'b1;
      #1;
      check("abort_ready_en", 0, char_ready, 1'b1);
    end

    // 'S' interrupted by reset, then 'E' with clean timing
    wait_ready(got);
    if (got) begin
      accept(18);
      for (int k = 1; k <= 10; k++) @(negedge clk);
      check("s_mark_c10", 10, morse_out, 1'b1);
      rst = 1'b0;
      #1;
      check("mid_rst_morse", 10, morse_out, 1'b0);
      check("mid_rst_busy", 10, busy, 1'b0);
      check("mid_rst_done", 10, done, 1'b0);
      check("mid_rst_err", 10, err, 1'b0);
      check("mid_rst_ready", 10, char_ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_char(4, 1'b0);
    end

    for (int i = 0; i < 12; i++) begin
      code = int'($urandom_range(0, 63));
      run_char(code, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
